// File: rtl/jtdsp16_ctrl.sv
// JTDSP16 program sequencer and instruction decoder.
// Fetches from a combinational program ROM and drives the data arithmetic unit strobes.
module jtdsp16_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_dout,
  input  logic          con_result,
  output logic          dec_en,
  output logic          con_en,
  output logic [4:0]    t_field,
  output logic [5:0]    op_fields,
  output logic [2:0]    r_field,
  output logic          ram_load,
  output logic          imm_load,
  output logic          rmux_load,
  output logic          alu_sel,
  output logic          st_a0h,
  output logic          st_a1h,
  output logic [15:0]   long_imm
);

  localparam logic [4:0] TGoto0 = 5'h00;
  localparam logic [4:0] TGoto1 = 5'h01;
  localparam logic [4:0] TCall0 = 5'h10;
  localparam logic [4:0] TCall1 = 5'h11;
  localparam logic [4:0] TRet   = 5'h18;
  localparam logic [4:0] TF1    = 5'h06;
  localparam logic [4:0] TF1Ram = 5'h07;
  localparam logic [4:0] TRRam  = 5'h0C;
  localparam logic [4:0] TRmux  = 5'h0B;
  localparam logic [4:0] TRImm  = 5'h0A;
  localparam logic [4:0] TSkip  = 5'h1A;
  localparam logic [4:0] TDo    = 5'h0E;

  typedef enum logic [1:0] {StExec, StImm, StRep} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pr_q, pr_d;
  logic [6:0]    rep_q, rep_d;
  logic [2:0]    r_lat_q, r_lat_d;

  logic [4:0]    t;
  logic [AW-1:0] ja, pc_inc;
  logic [6:0]    k;
  logic          flow;

  assign t        = rom_dout[15:11];
  assign ja       = AW'(rom_dout[11:0]);
  assign k        = rom_dout[6:0];
  assign pc_inc   = pc_q + AW'(1);
  assign rom_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StExec;
      pc_q    <= '0;
      pr_q    <= '0;
      rep_q   <= '0;
      r_lat_q <= '0;
    end else if (cen) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pr_q    <= pr_d;
      rep_q   <= rep_d;
      r_lat_q <= r_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_inc;
    pr_d    = pr_q;
    rep_d   = rep_q;
    r_lat_d = r_lat_q;
    flow    = 1'b0;
    if (state_q == StImm) begin
      state_d = StExec;
    end else begin
      case (t)
        TGoto0, TGoto1: begin
          pc_d = ja;
          flow = 1'b1;
        end
        TCall0, TCall1: begin
          pr_d = pc_inc;
          pc_d = ja;
          flow = 1'b1;
        end
        TRet: begin
          pc_d = pr_q;
          flow = 1'b1;
        end
        TSkip: begin
          pc_d = con_result ? pc_inc : pc_q + AW'(2);
          flow = 1'b1;
        end
        TDo: begin
          flow = 1'b1;
          if (state_q == StExec && k != 7'd0) begin
            rep_d   = k;
            state_d = StRep;
          end
        end
        TRImm: begin
          r_lat_d = rom_dout[6:4];
          state_d = StImm;
          flow    = 1'b1;
        end
        default: ;
      endcase
      // Inside a repeat, flow or two-word opcodes run once and end the loop.
      if (state_q == StRep) begin
        if (flow) begin
          rep_d = '0;
          if (t != TRImm) state_d = StExec;
        end else if (rep_q > 7'd1) begin
          rep_d = rep_q - 7'd1;
          pc_d  = pc_q;
        end else begin
          rep_d   = '0;
          state_d = StExec;
        end
      end
    end
  end

  always_comb begin
    dec_en    = 1'b0;
    con_en    = 1'b0;
    ram_load  = 1'b0;
    imm_load  = 1'b0;
    rmux_load = 1'b0;
    alu_sel   = 1'b0;
    st_a0h    = 1'b0;
    st_a1h    = 1'b0;
    if (state_q == StImm) begin
      t_field   = '0;
      op_fields = '0;
      r_field   = r_lat_q;
      long_imm  = rom_dout;
    end else begin
      t_field   = t;
      op_fields = rom_dout[10:5];
      r_field   = rom_dout[6:4];
      long_imm  = '0;
    end
    if (cen && !rst) begin
      if (state_q == StImm) begin
        imm_load = 1'b1;
      end else begin
        case (t)
          TF1:    dec_en = 1'b1;
          TF1Ram: begin
            dec_en  = 1'b1;
            alu_sel = 1'b1;
          end
          TRRam:  ram_load = 1'b1;
          TRmux:  begin
            rmux_load = 1'b1;
            st_a0h    = ~rom_dout[10];
            st_a1h    = rom_dout[10];
          end
          TSkip:  con_en = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_ctrl.sv
// Directed bench for jtdsp16_ctrl: ROM model plus an expected-output scoreboard queue.
module tb_jtdsp16_ctrl;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_dout;
  logic          con_result = 1'b0;
  logic          dec_en, con_en, ram_load, imm_load, rmux_load, alu_sel, st_a0h, st_a1h;
  logic [4:0]    t_field;
  logic [5:0]    op_fields;
  logic [2:0]    r_field;
  logic [15:0]   long_imm;

  logic [15:0] rom [0:(1<<AW)-1];
  assign rom_dout = rom[rom_addr];

  jtdsp16_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .con_result(con_result), .dec_en(dec_en), .con_en(con_en), .t_field(t_field),
    .op_fields(op_fields), .r_field(r_field), .ram_load(ram_load), .imm_load(imm_load),
    .rmux_load(rmux_load), .alu_sel(alu_sel), .st_a0h(st_a0h), .st_a1h(st_a1h),
    .long_imm(long_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [44:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Strobe order: {dec_en, con_en, alu_sel, ram_load, imm_load, rmux_load, st_a0h, st_a1h}
  localparam logic [7:0] SNone = 8'b0000_0000;
  localparam logic [7:0] SF1   = 8'b1000_0000;
  localparam logic [7:0] SF1R  = 8'b1010_0000;
  localparam logic [7:0] SCon  = 8'b0100_0000;
  localparam logic [7:0] SRam  = 8'b0001_0000;
  localparam logic [7:0] SImm  = 8'b0000_1000;
  localparam logic [7:0] SA0h  = 8'b0000_0110;
  localparam logic [7:0] SA1h  = 8'b0000_0101;

  task automatic clear_rom();
    for (int i = 0; i < (1 << AW); i++) rom[i] = 16'hF800;
  endtask

  task automatic exp_exec(input string tag, input logic [AW-1:0] pc, input logic [7:0] s);
    exp_t e;
    logic [15:0] w;
    w = rom[pc];
    e.tag = tag;
    e.v = {pc, w[10:5], s, w[6:4], 16'h0000};
    q.push_back(e);
  endtask

  task automatic exp_imm(input string tag, input logic [AW-1:0] pc, input logic [2:0] r,
                         input logic [15:0] li);
    exp_t e;
    e.tag = tag;
    e.v = {pc, 6'd0, SImm, r, li};
    q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    logic [44:0] obs;
    @(negedge clk);
    obs = {rom_addr, op_fields, dec_en, con_en, alu_sel, ram_load, imm_load, rmux_load,
           st_a0h, st_a1h, r_field, long_imm};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cen = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clear_rom();
    rom[0] = 16'h3000;
    rom[1] = 16'h0005;
    // Strobes held low during reset even though ROM[0] is an F1 op.
    exp_exec("reset", 0, SNone);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;

    exp_exec("f1", 0, SF1);         step();
    exp_exec("goto5", 1, SNone);    step();
    exp_exec("at5", 5, SNone);      step();

    // Two-word immediate load
    clear_rom(); rom[0] = 16'h5030; rom[1] = 16'h1234; reset_dut();
    exp_exec("rimm_w1", 0, SNone);  step();
    exp_imm("rimm_w2", 1, 3'd3, 16'h1234); step();
    exp_exec("rimm_next", 2, SNone); step();

    // Conditional skip, false then true
    clear_rom(); rom[0] = 16'hD140; con_result = 1'b0; reset_dut();
    exp_exec("skip0_con", 0, SCon); step();
    exp_exec("skip0_pc", 2, SNone); step();
    con_result = 1'b1; reset_dut();
    exp_exec("skip1_con", 0, SCon); step();
    exp_exec("skip1_pc", 1, SNone); step();
    con_result = 1'b0;

    // do 3 with continuous cen
    clear_rom(); rom[0] = 16'h7003; rom[1] = 16'h6040; reset_dut();
    exp_exec("do3", 0, SNone);      step();
    for (int i = 0; i < 3; i++) begin
      exp_exec("rep_ram", 1, SRam); step();
    end
    exp_exec("rep_exit", 2, SNone); step();

    // do 3 with cen toggling inside the loop
    reset_dut();
    exp_exec("do3_cen", 0, SNone);  step();
    for (int i = 0; i < 5; i++) begin
      cen = (i % 2 == 0);
      exp_exec(cen ? "rep_cen1" : "rep_cen0", 1, cen ? SRam : SNone);
      step();
    end
    cen = 1'b1;
    exp_exec("rep_cen_exit", 2, SNone); step();

    // call/return
    clear_rom(); rom[0] = 16'h8020; rom[12'h020] = 16'hC000; reset_dut();
    exp_exec("call", 0, SNone);     step();
    exp_exec("ret", 12'h020, SNone); step();
    exp_exec("after_ret", 1, SNone); step();

    // F1 with RAM operand, and both accumulator-high stores
    clear_rom(); rom[0] = 16'h3800; rom[1] = 16'h5800; rom[2] = 16'h5C00; reset_dut();
    exp_exec("f1_ram", 0, SF1R);    step();
    exp_exec("st_a0h", 1, SA0h);    step();
    exp_exec("st_a1h", 2, SA1h);    step();

    // pc wraps from the top address to 0
    clear_rom(); rom[0] = 16'h0FFF; reset_dut();
    exp_exec("goto_top", 0, SNone); step();
    exp_exec("at_top", 12'hFFF, SNone); step();
    exp_exec("wrap", 0, SNone);     step();

    // Reset while in the immediate-word cycle
    clear_rom(); rom[0] = 16'h5030; rom[1] = 16'h1234; reset_dut();
    exp_exec("rimm_pre", 0, SNone); step();
    rst = 1'b1;
    exp_exec("rst_in_imm", 0, SNone); sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_exec("refetch", 0, SNone);  step();
    exp_imm("refetch_imm", 1, 3'd3, 16'h1234); step();

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
